// File: rtl/cordic_atan2.sv
// rtl/cordic_atan2.sv - iterative vectoring CORDIC: sign-magnitude sin/cos to phase and magnitude
module cordic_atan2 #(
  parameter int ITER = 18
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [18:0] sin_in,
  input  logic [18:0] cos_in,
  output logic [19:0] angle,
  output logic [19:0] mag,
  output logic        out_valid
);

  typedef enum logic [1:0] {S_IDLE, S_PREROT, S_ITER, S_DONE} state_t;

  localparam logic [4:0] LAST_STEP = 5'(ITER - 1);

  state_t             state;
  state_t             state_nxt;
  logic signed [22:0] x;
  logic signed [22:0] y;
  logic        [19:0] z;
  logic         [4:0] iter_cnt;
  logic               zero_in;
  logic               transfer;

  logic signed [22:0] x_sh;
  logic signed [22:0] y_sh;
  logic signed [22:0] x_step;
  logic signed [22:0] y_step;
  logic        [19:0] z_step;
  logic        [19:0] a_i;
  logic               dir;

  // Sign-magnitude to 23-bit two's complement with 2 guard bits; -0 folds to 0
  function automatic logic signed [22:0] to_twos(input logic [18:0] sm);
    logic signed [22:0] m;
    m = $signed({3'b000, sm[17:0], 2'b00});
    return sm[18] ? -m : m;
  endfunction

  // Handshake flags and state transitions
  always_comb begin
    state_nxt = state;
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    transfer  = in_valid && (state == S_IDLE);
    case (state)
      S_IDLE:   if (transfer) state_nxt = S_PREROT;
      S_PREROT: state_nxt = S_ITER;
      S_ITER:   if (iter_cnt == LAST_STEP) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // atan(2^-i) scaled so that a full circle is 2^20
  always_comb begin
    a_i = 20'd0;
    case (iter_cnt)
      5'd0:  a_i = 20'd131072;
      5'd1:  a_i = 20'd77376;
      5'd2:  a_i = 20'd40884;
      5'd3:  a_i = 20'd20753;
      5'd4:  a_i = 20'd10417;
      5'd5:  a_i = 20'd5213;
      5'd6:  a_i = 20'd2607;
      5'd7:  a_i = 20'd1304;
      5'd8:  a_i = 20'd652;
      5'd9:  a_i = 20'd326;
      5'd10: a_i = 20'd163;
      5'd11: a_i = 20'd81;
      5'd12: a_i = 20'd41;
      5'd13: a_i = 20'd20;
      5'd14: a_i = 20'd10;
      5'd15: a_i = 20'd5;
      5'd16: a_i = 20'd3;
      5'd17: a_i = 20'd1;
      5'd18: a_i = 20'd1;
      default: a_i = 20'd0;
    endcase
  end

  // One micro-rotation driving y towards zero; shifts use the pre-update x/y
  always_comb begin
    x_sh   = x >>> iter_cnt;
    y_sh   = y >>> iter_cnt;
    dir    = !y[22];
    x_step = dir ? (x + y_sh) : (x - y_sh);
    y_step = dir ? (y - x_sh) : (y + x_sh);
    z_step = dir ? (z + a_i) : (z - a_i);
  end

  // Datapath: capture, half-plane pre-rotation, iterations, result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x        <= '0;
      y        <= '0;
      z        <= '0;
      iter_cnt <= '0;
      zero_in  <= 1'b0;
      angle    <= '0;
      mag      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (transfer) begin
            x       <= to_twos(cos_in);
            y       <= to_twos(sin_in);
            zero_in <= (sin_in[17:0] == 18'd0) && (cos_in[17:0] == 18'd0);
          end
        end
        S_PREROT: begin
          iter_cnt <= '0;
          if (x[22]) begin
            x <= -x;
            y <= -y;
            z <= 20'h80000;
          end else begin
            z <= '0;
          end
        end
        S_ITER: begin
          x        <= x_step;
          y        <= y_step;
          z        <= z_step;
          iter_cnt <= iter_cnt + 5'd1;
          if (iter_cnt == LAST_STEP) begin
            // A zero vector leaves z at the sum of the table; report 0 instead
            angle <= zero_in ? 20'd0 : z_step;
            mag   <= 20'(x_step >>> 2);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_atan2.sv
// tb/tb_cordic_atan2.sv - scoreboard bench for cordic_atan2 with directed vectors
module tb_cordic_atan2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [18:0] sin_in;
  logic [18:0] cos_in;
  logic [19:0] angle;
  logic [19:0] mag;
  logic        out_valid;

  cordic_atan2 #(.ITER(18)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sin_in    (sin_in),
    .cos_in    (cos_in),
    .angle     (angle),
    .mag       (mag),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] ea;
    logic [19:0] em;
    int          t;
  } exp_t;

  typedef struct {
    logic [18:0] s;
    logic [18:0] c;
    logic [19:0] ea;
    logic [19:0] em;
  } vec_t;

  exp_t sb[$];
  vec_t vec[12];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   cont_mode = 1'b0;
  int   last_ov = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input bit ok, input int act, input int req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int circ_err(input logic [19:0] a, input logic [19:0] b);
    int e;
    e = int'(a) - int'(b);
    if (e > 524288)  e -= 1048576;
    if (e < -524288) e += 1048576;
    return (e < 0) ? -e : e;
  endfunction

  function automatic logic [18:0] sm(input int v);
    return (v < 0) ? {1'b1, 18'(-v)} : {1'b0, 18'(v)};
  endfunction

  // Monitor: every out_valid must match the oldest accepted sample
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 1'b0, 1, 0);
      end else begin
        exp_t e;
        int   dm;
        e  = sb.pop_front();
        dm = int'(mag) - int'(e.em);
        chk("angle", circ_err(angle, e.ea) <= 4, int'(angle), int'(e.ea));
        chk("mag", (dm <= 4) && (dm >= -4), int'(mag), int'(e.em));
        chk("latency", (cyc + 1 - e.t) == 20, cyc + 1 - e.t, 20);
      end
      if (cont_mode) begin
        if (last_ov >= 0) chk("ov_period", (cyc - last_ov) == 21, cyc - last_ov, 21);
        last_ov = cyc;
      end
    end
  end

  task automatic send(input int idx);
    int   waited;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    sin_in   = vec[idx].s;
    cos_in   = vec[idx].c;
    waited   = 0;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 1'b0, waited, 0);
    end else begin
      e.ea = vec[idx].ea;
      e.em = vec[idx].em;
      e.t  = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    sin_in   = 19'($urandom);
    cos_in   = 19'($urandom);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 1'b0, sb.size(), 0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int   accepted;
    exp_t e;
    vec[0]  = '{sm(0),        sm(100000),  20'd0,      20'd164676};
    vec[1]  = '{sm(100000),   sm(0),       20'd262144, 20'd164676};
    vec[2]  = '{sm(0),        sm(-100000), 20'd524288, 20'd164676};
    vec[3]  = '{sm(-70711),   sm(70711),   20'd917504, 20'd164676};
    vec[4]  = '{sm(0),        sm(0),       20'd0,      20'd0};
    vec[5]  = '{19'h40000,    19'h40000,   20'd0,      20'd0};
    vec[6]  = '{sm(100000),   sm(100000),  20'd131072, 20'd232887};
    vec[7]  = '{sm(100000),   sm(-100000), 20'd393216, 20'd232887};
    vec[8]  = '{sm(-100000),  sm(-100000), 20'd655360, 20'd232887};
    vec[9]  = '{sm(0),        sm(262143),  20'd0,      20'd431687};
    vec[10] = '{sm(-262143),  sm(-262143), 20'd655360, 20'd610498};
    vec[11] = '{sm(-100000),  sm(0),       20'd786432, 20'd164676};

    in_valid = 1'b0;
    sin_in   = '0;
    cos_in   = '0;
    reset_n  = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_in_ready", in_ready == 1'b1, int'(in_ready), 1);
    chk("rst_out_valid", out_valid == 1'b0, int'(out_valid), 0);
    chk("rst_angle", angle == 20'd0, int'(angle), 0);
    chk("rst_mag", mag == 20'd0, int'(mag), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) send(i);
    wait_drain();

    // Continuous in_valid with a fresh sample every cycle
    cont_mode = 1'b1;
    last_ov   = -1;
    accepted  = 0;
    for (int k = 0; k < 105; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      sin_in   = vec[k % 12].s;
      cos_in   = vec[k % 12].c;
      if (in_ready) begin
        e.ea = vec[k % 12].ea;
        e.em = vec[k % 12].em;
        e.t  = cyc + 1;
        sb.push_back(e);
        accepted++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("cont_accepted", accepted == 5, accepted, 5);
    wait_drain();
    cont_mode = 1'b0;

    // Abort a computation with reset at cycle 10
    send(6);
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready == 1'b1, int'(in_ready), 1);
    chk("abort_out_valid", out_valid == 1'b0, int'(out_valid), 0);
    chk("abort_mag", mag == 20'd0, int'(mag), 0);
    if (sb.size() != 0) e = sb.pop_back();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    send(10);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
